// File: rtl/dds_sweep_ctrl.sv
// DDS sweep scheduler: steps the frequency word between two limits with a
// programmable dwell, in single, sawtooth or triangle mode.
module dds_sweep_ctrl #(
    parameter int FW = 26,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [FW-1:0] cfg_f_start,
    input  logic [FW-1:0] cfg_f_stop,
    input  logic [FW-1:0] cfg_f_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic [1:0]    cfg_wave_c,
    input  logic [4:0]    cfg_amplitude,
    output logic [FW-1:0] f_word,
    output logic [1:0]    wave_c,
    output logic [4:0]    amplitude,
    output logic          busy,
    output logic          sweep_tick,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN_UP,
        RUN_DOWN
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] f_start_q, f_start_d;
    logic [FW-1:0] f_stop_q, f_stop_d;
    logic [FW-1:0] f_step_q, f_step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [FW-1:0] f_word_d;
    logic [1:0]    wave_c_d;
    logic [4:0]    amplitude_d;
    logic          tick_d, done_d, err_d;

    logic [FW:0]   up_sum;
    logic [FW-1:0] up_next;
    logic [FW-1:0] dn_diff;
    logic [FW-1:0] dn_next;
    logic          cfg_bad;

    // One extra bit on the sum so a step near full scale clamps instead of wrapping
    assign up_sum  = {1'b0, f_word} + {1'b0, f_step_q};
    assign up_next = (up_sum >= {1'b0, f_stop_q}) ? f_stop_q : up_sum[FW-1:0];
    assign dn_diff = f_word - f_start_q;
    assign dn_next = (dn_diff <= f_step_q) ? f_start_q : f_word - f_step_q;

    assign cfg_bad = (cfg_f_step == '0) || (cfg_f_start > cfg_f_stop) ||
                     (cfg_mode == 2'd3);

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        f_start_d   = f_start_q;
        f_stop_d    = f_stop_q;
        f_step_d    = f_step_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        f_word_d    = f_word;
        wave_c_d    = wave_c;
        amplitude_d = amplitude;
        tick_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    f_start_d = cfg_f_start;
                    f_stop_d  = cfg_f_stop;
                    f_step_d  = cfg_f_step;
                    dwell_d   = cfg_dwell;
                    mode_d    = cfg_mode;
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        f_word_d    = cfg_f_start;
                        wave_c_d    = cfg_wave_c;
                        amplitude_d = cfg_amplitude;
                        cnt_d       = cfg_dwell;
                        tick_d      = 1'b1;
                        state_d     = RUN_UP;
                    end
                end
            end
            RUN_UP, RUN_DOWN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DW'(1);
                end else begin
                    cnt_d  = dwell_q;
                    tick_d = 1'b1;
                    if (state_q == RUN_UP) begin
                        if (f_word == f_stop_q) begin
                            case (mode_q)
                                2'd0: begin
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                    tick_d  = 1'b0;
                                end
                                2'd1: f_word_d = f_start_q;
                                default: begin
                                    state_d  = RUN_DOWN;
                                    f_word_d = dn_next;
                                end
                            endcase
                        end else begin
                            f_word_d = up_next;
                        end
                    end else begin
                        if (f_word == f_start_q) begin
                            state_d  = RUN_UP;
                            f_word_d = up_next;
                        end else begin
                            f_word_d = dn_next;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            f_start_q  <= '0;
            f_stop_q   <= '0;
            f_step_q   <= '0;
            dwell_q    <= '0;
            cnt_q      <= '0;
            mode_q     <= '0;
            f_word     <= '0;
            wave_c     <= '0;
            amplitude  <= '0;
            sweep_tick <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_start_q  <= f_start_d;
            f_stop_q   <= f_stop_d;
            f_step_q   <= f_step_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            f_word     <= f_word_d;
            wave_c     <= wave_c_d;
            amplitude  <= amplitude_d;
            sweep_tick <= tick_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule
